// File: rtl/mem_read_ctrl_if.sv
// Request and memory-side bus of the read controller.
// slave = controller side, master = requester/memory side.
interface mem_read_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic              busy;

  modport slave (
    input  req_valid, req_addr,
    input  mem_ack, mem_data,
    output req_ready, mem_addr, mem_rd,
    output rd_data, rd_valid, rd_err, busy
  );

  modport master (
    output req_valid, req_addr,
    output mem_ack, mem_data,
    input  req_ready, mem_addr, mem_rd,
    input  rd_data, rd_valid, rd_err, busy
  );
endinterface

// File: rtl/mem_read_ctrl.sv
// Single-outstanding memory read controller with ack timeout.
// Completion is a one-cycle rd_valid pulse decoded from DONE.
module mem_read_ctrl #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           clr,
  mem_read_ctrl_if.slave bus
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              rd, rd_n;
  logic [DATA_W-1:0] data, data_n;
  logic              err, err_n;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      cnt   <= '0;
      addr  <= '0;
      rd    <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      addr  <= addr_n;
      rd    <= rd_n;
      data  <= data_n;
      err   <= err_n;
    end
  end

  // Ack is tested before expiry so a same-edge ack wins.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    rd_n    = rd;
    data_n  = data;
    err_n   = err;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          addr_n  = bus.req_addr;
          rd_n    = 1'b1;
          cnt_n   = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          data_n  = bus.mem_data;
          err_n   = 1'b0;
          rd_n    = 1'b0;
          state_n = DONE;
        end else if (cnt == CMAX) begin
          data_n  = '0;
          err_n   = 1'b1;
          rd_n    = 1'b0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.rd_valid  = (state == DONE);
  assign bus.mem_addr  = addr;
  assign bus.mem_rd    = rd;
  assign bus.rd_data   = data;
  assign bus.rd_err    = err;
endmodule

// File: tb/tb_mem_read_ctrl.sv
// Directed + random bench for mem_read_ctrl.
// Reference: per-read latency/status derived from ack cycle vs timeout.
module tb_mem_read_ctrl;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int T  = 15;

  logic clk;
  logic clr;
  int   vectors;
  int   miscompares;

  logic [DW-1:0] exp_data;
  logic          exp_err;

  mem_read_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_read_ctrl #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input logic [AW-1:0] a);
    chk("idle_ready", 32'(bus.req_ready), 32'd1);
    chk("idle_busy",  32'(bus.busy),      32'd0);
    chk("idle_valid", 32'(bus.rd_valid),  32'd0);
    chk("idle_mem_rd", 32'(bus.mem_rd),   32'd0);
    chk("idle_addr",  32'(bus.mem_addr),  32'(a));
    chk("idle_data",  bus.rd_data,        exp_data);
    chk("idle_err",   32'(bus.rd_err),    32'(exp_err));
  endtask

  // ack_k: WAIT cycle that sees mem_ack (1..T), anything else = no ack.
  task automatic do_read(input logic [AW-1:0] a,
                         input logic [DW-1:0] d,
                         input int ack_k,
                         input bit late,
                         input bit hold);
    bit ok;
    int lat;
    ok  = (ack_k >= 1) && (ack_k <= T);
    lat = ok ? ack_k : T;
    chk("acc_ready", 32'(bus.req_ready), 32'd1);
    chk("acc_valid", 32'(bus.rd_valid),  32'd0);
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.mem_ack   = 1'b0;
    @(negedge clk);
    if (!hold) bus.req_valid = 1'b0;
    bus.req_addr = AW'($urandom);
    for (int c = 1; c <= lat; c++) begin
      chk("wait_rd",    32'(bus.mem_rd),    32'd1);
      chk("wait_addr",  32'(bus.mem_addr),  32'(a));
      chk("wait_busy",  32'(bus.busy),      32'd1);
      chk("wait_ready", 32'(bus.req_ready), 32'd0);
      chk("wait_valid", 32'(bus.rd_valid),  32'd0);
      chk("wait_data",  bus.rd_data,        exp_data);
      chk("wait_err",   32'(bus.rd_err),    32'(exp_err));
      bus.mem_ack  = (c == ack_k);
      bus.mem_data = (c == ack_k) ? d : DW'($urandom);
      @(negedge clk);
    end
    exp_data = ok ? d : '0;
    exp_err  = !ok;
    chk("done_valid", 32'(bus.rd_valid),  32'd1);
    chk("done_data",  bus.rd_data,        exp_data);
    chk("done_err",   32'(bus.rd_err),    32'(exp_err));
    chk("done_rd",    32'(bus.mem_rd),    32'd0);
    chk("done_ready", 32'(bus.req_ready), 32'd0);
    chk("done_busy",  32'(bus.busy),      32'd1);
    bus.mem_ack  = late;
    bus.mem_data = DW'($urandom);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk_idle(a);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    exp_data      = '0;
    exp_err       = 1'b0;
    clr           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_data  = '0;

    repeat (2) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    chk_idle('0);

    do_read(9'h05A, 32'hDEADBEEF, 1, 1'b0, 1'b0);
    do_read(9'h1C3, 32'h12345678, 4, 1'b0, 1'b0);
    do_read(9'h0F0, 32'hCAFEF00D, 0, 1'b1, 1'b0);
    do_read(9'h111, 32'hA5A5_5A5A, T, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++)
      do_read(AW'(i * 37 + 3), DW'($urandom), 1, 1'b0, 1'b1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk_idle(AW'(2 * 37 + 3));

    chk("mr_ready", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_addr  = 9'h0AA;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("mr_rd_before", 32'(bus.mem_rd), 32'd1);
    clr = 1'b0;
    #1;
    chk("mr_rd",    32'(bus.mem_rd),    32'd0);
    chk("mr_busy",  32'(bus.busy),      32'd0);
    chk("mr_valid", 32'(bus.rd_valid),  32'd0);
    chk("mr_ready2", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    clr         = 1'b1;
    exp_data    = '0;
    exp_err     = 1'b0;
    bus.mem_ack = 1'b1;
    @(negedge clk);
    chk("mr_stray_valid", 32'(bus.rd_valid), 32'd0);
    chk("mr_stray_busy",  32'(bus.busy),     32'd0);
    bus.mem_ack = 1'b0;
    do_read(9'h077, 32'h0BADF00D, 2, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++)
      do_read(AW'($urandom), DW'($urandom),
              int'($urandom_range(0, T + 2)),
              1'($urandom_range(0, 1)), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_read_ctrl.md
# mem_read_ctrl

Read-side controller for the CPU's memory interface. It accepts one read request at a time from the datapath control and drives the address and read strobe to the memory. It waits for the memory acknowledge, bounded by a timeout, and then returns the read word with a one-cycle valid pulse. It sits between the control unit / MAR path and the MDR input, and complements the write path into the general registers by sourcing data out of storage.

## Interface
Parameters:
- ADDR_W, 9: memory word-address width (512-word memory).
- DATA_W, 32: data word width.
- TIMEOUT, 15: maximum number of WAIT cycles allowed for mem_ack before an error completion. Legal range is TIMEOUT >= 1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  asynchronous, active-low reset (clr=0 resets immediately, independent of clk).
- req_valid  in  1  read request present.
- req_ready  out  1  block can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  address of the requested word; sampled at acceptance.
- mem_addr  out  ADDR_W  registered address driven to memory.
- mem_rd  out  1  registered read strobe to memory.
- mem_ack  in  1  memory acknowledge; mem_data is valid in the same cycle.
- mem_data  in  DATA_W  read data from memory.
- rd_data  out  DATA_W  returned word; held until the next completion.
- rd_valid  out  1  one-cycle completion pulse.
- rd_err  out  1  completion status; 1 = timeout. Valid with rd_valid and held until the next completion.
- busy  out  1  high whenever state is not IDLE.

## Operation
States: IDLE, WAIT, DONE. An internal counter cnt is clog2(TIMEOUT) bits wide, with a minimum width of 1.

- **Reset values (clr=0):** state=IDLE, mem_addr=0, mem_rd=0, rd_data=0, rd_valid=0, rd_err=0, cnt=0. Consequently busy=0 and req_ready=1.
- **IDLE:**
  - req_ready=1.
  - If req_valid=1 at the edge: mem_addr<=req_addr, mem_rd<=1, cnt<=0, go to WAIT.
  - mem_ack is ignored.
- **WAIT:** mem_rd=1 and mem_addr is held stable. At each edge, evaluated in priority order:
  - If mem_ack=1: rd_data<=mem_data, rd_err<=0, mem_rd<=0, go to DONE.
  - Else if cnt==TIMEOUT-1: rd_data<=0, rd_err<=1, mem_rd<=0, go to DONE.
  - Else: cnt<=cnt+1.
- **DONE:**
  - rd_valid=1, decoded from state.
  - req_ready=0, so a request present in this cycle is not accepted.
  - mem_ack is ignored.
  - Next edge goes to IDLE unconditionally.
- **Hold rules:**
  - mem_addr, rd_data and rd_err are held in IDLE until the next acceptance or completion.
  - rd_data and rd_err do not change during WAIT.
- **Simultaneous events:** mem_ack arriving on the same edge as timeout expiry counts as success (ack has priority).
- **Late acknowledge:** a mem_ack that arrives after a timeout, while in DONE or IDLE, is ignored. It does not affect the next request unless it arrives while that request is in WAIT.
- **Reset mid-operation:** asserting clr in WAIT or DONE aborts the transaction. mem_rd and rd_valid drop asynchronously and no completion is reported.

## Timing
- Request is accepted on edge E0, with req_valid and req_ready both high in the preceding cycle.
- mem_rd and mem_addr are valid from just after E0.
- Fastest completion: mem_ack high in the first WAIT cycle is sampled at E1, and rd_valid is high for the cycle between E1 and E2.
  - Request-to-rd_valid latency is 2 cycles.
  - Maximum sustained throughput is 1 read per 3 cycles.
- Ack sampled at WAIT cycle k (k=1..TIMEOUT) gives rd_valid in cycle k+1 after E0.
- Timeout: with no ack, mem_rd is high for exactly TIMEOUT cycles. rd_valid with rd_err=1 follows in cycle TIMEOUT+1 after E0.
- rd_valid is never high for more than one consecutive cycle.
- All outputs are registered or decoded from state; there is no combinational path from req_* or mem_* to any output.

## Test plan
1. **Reset values:** hold clr=0 for 2 cycles, then release. Check every output equals its reset value and req_ready=1.
2. **Single-cycle ack:** req_addr=0x05A with req_valid for one cycle; memory acks in the first WAIT cycle with mem_data=0xDEADBEEF.
   - mem_rd is high for 1 cycle with mem_addr=0x05A.
   - rd_valid pulses 2 cycles after acceptance with rd_data=0xDEADBEEF and rd_err=0.
3. **Delayed ack:** ack after 4 WAIT cycles with mem_data=0x12345678.
   - mem_rd is high for 4 cycles.
   - rd_valid follows in the next cycle with the correct data and rd_err=0.
4. **Timeout:** TIMEOUT=15, memory never acks.
   - mem_rd is high for 15 cycles.
   - rd_valid then pulses with rd_err=1 and rd_data=0.
   - A late ack in the DONE cycle is ignored.
5. **Ack on the expiry edge:** ack exactly in WAIT cycle 15.
   - Completion reports success (rd_err=0) with mem_data captured.
6. **Back-to-back requests and mid-read reset:**
   - req_valid held high continuously: accepts occur every 3 cycles with immediate acks, and req_ready=0 during WAIT and DONE.
   - clr pulsed low during WAIT: mem_rd and busy drop at once, no rd_valid is produced, and the next request completes normally.
